// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: command opcodes, FSM states,
// default counter width and the wrap-step predicate.
package counter_seq_pkg;

  localparam int CNT_WIDTH_DEF = 10;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // A step wraps when counting up from all-ones or down from all-zeros.
  function automatic logic is_wrap_step(input logic mode_up,
                                        input logic all_ones,
                                        input logic all_zeros);
    return mode_up ? all_ones : all_zeros;
  endfunction

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Command handshake bundle between the control logic (master) and the
// counter sequencer (slave).
interface counter_seq_ctrl_if
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
);
  logic             cmd_valid;
  logic             cmd_ready;
  op_e              cmd_op;
  logic [WIDTH-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/counter_seq_ctrl_updown_counter_dp.sv
// WIDTH-bit up/down counter with parallel load; load has priority over a
// step. Driven by counter_seq_ctrl in integration and in the bench.
module updown_counter_dp
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next count: load, step up/down, or hold.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      q_d = mode_i ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
    end else begin
      q_d = q_q;
    end
  end

  // Count register with asynchronous reset to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command-driven sequencer for the up/down counter datapath. Accepts
// LOAD/UP/DOWN/NOP commands, drives the counter controls for an exact
// number of cycles, tracks wrap-around and pulses done on completion.
// Optional build macro COUNTER_SEQ_CTRL_SAT_EN: a RUN step that would wrap
// is withheld and the command finishes with wrapped set (saturation).
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH  = CNT_WIDTH_DEF,
  parameter int STEP_W = CNT_WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  counter_seq_ctrl_if.slave cmd_if,
  input  logic              abort,
  output logic              cnt_en,
  output logic              cnt_mode,
  output logic              cnt_load,
  output logic [WIDTH-1:0]  cnt_load_val,
  input  logic [WIDTH-1:0]  cnt_q,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              wrapped
);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] remaining_q, remaining_d;
  logic              mode_q, mode_d;
  logic [WIDTH-1:0]  load_val_q, load_val_d;
  logic              wrapped_q, wrapped_d;
  logic              aborted_q, aborted_d;
  logic              wrap_hit_s;
  logic              step_s;

  // Step issue: only in RUN, never in an abort cycle, and (saturating
  // build) never when the step would wrap.
  always_comb begin
    wrap_hit_s = is_wrap_step(mode_q, &cnt_q, ~|cnt_q);
`ifdef COUNTER_SEQ_CTRL_SAT_EN
    step_s = (state_q == S_RUN) && !abort && !wrap_hit_s;
`else
    step_s = (state_q == S_RUN) && !abort;
`endif
  end

  // Next-state and captured-command logic.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    mode_d      = mode_q;
    load_val_d  = load_val_q;
    wrapped_d   = wrapped_q;
    aborted_d   = aborted_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_if.cmd_valid) begin
          wrapped_d = 1'b0;
          aborted_d = 1'b0;
          case (cmd_if.cmd_op)
            OP_LOAD: begin
              load_val_d = cmd_if.cmd_arg;
              state_d    = S_LOAD;
            end
            OP_UP, OP_DOWN: begin
              mode_d      = (cmd_if.cmd_op == OP_UP);
              remaining_d = STEP_W'(cmd_if.cmd_arg);
              state_d     = (cmd_if.cmd_arg == '0) ? S_DONE : S_RUN;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        aborted_d = abort;
        state_d   = S_DONE;
      end
      S_RUN: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (!step_s) begin
          // Only reachable when a wrapping step was withheld.
          wrapped_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          remaining_d = remaining_q - STEP_W'(1);
          if (wrap_hit_s) begin
            wrapped_d = 1'b1;
          end else begin
            wrapped_d = wrapped_q;
          end
          if (remaining_q == STEP_W'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and command registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      mode_q      <= 1'b0;
      load_val_q  <= '0;
      wrapped_q   <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      mode_q      <= mode_d;
      load_val_q  <= load_val_d;
      wrapped_q   <= wrapped_d;
      aborted_q   <= aborted_d;
    end
  end

  assign cmd_if.cmd_ready = (state_q == S_IDLE);
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign cnt_en           = step_s;
  assign cnt_load         = (state_q == S_LOAD) && !abort;
  assign cnt_mode         = mode_q;
  assign cnt_load_val     = load_val_q;
  assign wrapped          = wrapped_q;
  assign aborted          = aborted_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl driving updown_counter_dp.
// A transaction-level model (command kind, steps left, integer counter
// value) predicts every output each cycle; directed scenarios pin the
// model with literal expectations, then randomized commands follow.
module tb_counter_seq_ctrl;
  import counter_seq_pkg::*;

  localparam int W    = 10;
  localparam int MAXV = (1 << W) - 1;
`ifdef COUNTER_SEQ_CTRL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         abort;
  logic         cnt_en, cnt_mode, cnt_load, busy, done, aborted, wrapped;
  logic [W-1:0] cnt_load_val, cnt_q;

  counter_seq_ctrl_if #(.WIDTH(W)) cmd_if ();

  counter_seq_ctrl #(.WIDTH(W), .STEP_W(W)) dut (
    .clk(clk), .rst(rst), .cmd_if(cmd_if), .abort(abort),
    .cnt_en(cnt_en), .cnt_mode(cnt_mode), .cnt_load(cnt_load),
    .cnt_load_val(cnt_load_val), .cnt_q(cnt_q), .busy(busy),
    .done(done), .aborted(aborted), .wrapped(wrapped)
  );

  updown_counter_dp #(.WIDTH(W)) u_dp (
    .clk(clk), .rst(rst), .en_i(cnt_en), .mode_i(cnt_mode),
    .load_i(cnt_load), .load_val_i(cnt_load_val), .q_o(cnt_q)
  );

  always #5 clk = ~clk;

  // Model: m_kind 0 idle, 1 loading, 2 stepping, 3 reporting done.
  int m_kind, m_left, m_cnt, m_lval;
  bit m_mode, m_wrapped, m_aborted, m_acc;
  int n_vec = 0, n_err = 0;
  int cyc = 0, acc_cyc, done_cyc, en_seen, load_seen;
  bit done_abort;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_kind = 0; m_left = 0; m_cnt = 0; m_lval = 0;
    m_mode = 1'b0; m_wrapped = 1'b0; m_aborted = 1'b0; m_acc = 1'b0;
  endtask

  function automatic bit model_would_wrap();
    return m_mode ? (m_cnt == MAXV) : (m_cnt == 0);
  endfunction

  task automatic check_outputs();
    bit ww;
    ww = model_would_wrap();
    chk("cmd_ready", cmd_if.cmd_ready, m_kind == 0);
    chk("busy", busy, m_kind != 0);
    chk("done", done, m_kind == 3);
    chk("cnt_load", cnt_load, (m_kind == 1) && !abort);
    chk("cnt_en", cnt_en, (m_kind == 2) && !abort && !(SAT && ww));
    chk("cnt_mode", cnt_mode, m_mode);
    chk("cnt_load_val", cnt_load_val, m_lval);
    chk("cnt_q", cnt_q, m_cnt);
    chk("wrapped", wrapped, m_wrapped);
    chk("aborted", aborted, m_aborted);
  endtask

  // Advance the model by one clock using the inputs held this cycle.
  task automatic model_step();
    bit ww;
    ww = model_would_wrap();
    case (m_kind)
      0: if (cmd_if.cmd_valid) begin
        m_acc = 1'b1; acc_cyc = cyc;
        m_wrapped = 1'b0; m_aborted = 1'b0;
        if (cmd_if.cmd_op == OP_LOAD) begin
          m_lval = int'(cmd_if.cmd_arg); m_kind = 1;
        end else if (cmd_if.cmd_op == OP_UP || cmd_if.cmd_op == OP_DOWN) begin
          m_mode = (cmd_if.cmd_op == OP_UP);
          m_left = int'(cmd_if.cmd_arg);
          m_kind = (m_left == 0) ? 3 : 2;
        end
      end
      1: begin
        if (abort) m_aborted = 1'b1;
        else m_cnt = m_lval;
        m_kind = 3;
      end
      2: begin
        if (abort) begin
          m_aborted = 1'b1; m_kind = 3;
        end else if (SAT && ww) begin
          m_wrapped = 1'b1; m_kind = 3;
        end else begin
          if (ww) m_wrapped = 1'b1;
          m_cnt = m_mode ? (m_cnt + 1) % (MAXV + 1) : (m_cnt + MAXV) % (MAXV + 1);
          m_left--;
          if (m_left == 0) m_kind = 3;
        end
      end
      default: m_kind = 0;
    endcase
  endtask

  // One clock: compare at negedge+1, advance model at posedge, return at negedge.
  task automatic tick();
    #1;
    check_outputs();
    if (cnt_en === 1'b1) en_seen++;
    if (cnt_load === 1'b1) load_seen++;
    if (done === 1'b1) begin
      done_cyc = cyc; done_abort = aborted;
    end
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_cmd(input op_e op, input int arg, input int abort_at);
    int guard, run_n;
    en_seen = 0; load_seen = 0; done_cyc = -1; acc_cyc = -1;
    done_abort = 1'b0; guard = 0; run_n = 0;
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = op; cmd_if.cmd_arg = arg[W-1:0];
    abort = 1'b0;
    tick();
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = OP_NOP;
    while (m_kind != 0 && guard < 3000) begin
      if (m_kind == 2) run_n++;
      abort = (m_kind == 2) && (run_n == abort_at);
      tick();
      guard++;
    end
    abort = 1'b0;
    if (guard >= 3000) chk("cmd_timeout", guard, 0);
  endtask

  initial begin
    int guard;
    int start;
    logic [W-1:0] a;
    model_reset();
    rst = 1'b1; abort = 1'b0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = OP_NOP; cmd_if.cmd_arg = '0;
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // LOAD 0x2A5: one load pulse, done two cycles after accept.
    run_cmd(OP_LOAD, 'h2A5, 0);
    chk("load_q", cnt_q, 10'h2A5);
    chk("load_pulses", load_seen, 1);
    chk("load_latency", done_cyc - acc_cyc, 2);

    // LOAD 0x3FE then UP 3 across the top.
    run_cmd(OP_LOAD, 'h3FE, 0);
    run_cmd(OP_UP, 3, 0);
    chk("wrap_steps", en_seen, SAT ? 1 : 3);
    chk("wrap_q", cnt_q, SAT ? 10'h3FF : 10'h001);
    chk("wrap_flag", wrapped, 1'b1);

    // DOWN 0: no steps, done one cycle after accept.
    run_cmd(OP_DOWN, 0, 0);
    chk("zero_steps", en_seen, 0);
    chk("zero_latency", done_cyc - acc_cyc, 1);
    chk("zero_ready", cmd_if.cmd_ready, 1'b1);

    // LOAD 0x100, UP 12 aborted in the 5th RUN cycle.
    run_cmd(OP_LOAD, 'h100, 0);
    run_cmd(OP_UP, 12, 5);
    chk("abort_steps", en_seen, 4);
    chk("abort_q", cnt_q, 10'h104);
    chk("abort_flag", done_abort, 1'b1);

    // Asynchronous reset in the middle of a run.
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = OP_UP; cmd_if.cmd_arg = 10'd20;
    tick();
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = OP_NOP;
    repeat (3) tick();
    #3 rst = 1'b1;
    #1;
    chk("rst_cnt_en", cnt_en, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cmd_if.cmd_ready, 1'b1);
    chk("rst_cnt_q", cnt_q, 10'h000);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_cmd(OP_UP, 2, 0);
    chk("post_rst_steps", en_seen, 2);
    chk("post_rst_q", cnt_q, 10'h002);

    // Continuous valid with alternating UP 1 / DOWN 1.
    start = m_cnt;
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_arg = 10'd1;
    for (int p = 0; p < 6; p++) begin
      for (int h = 0; h < 2; h++) begin
        cmd_if.cmd_op = (h == 0) ? OP_UP : OP_DOWN;
        m_acc = 1'b0; guard = 0;
        while (!m_acc && guard < 50) begin
          tick(); guard++;
        end
        if (!m_acc) chk("alt_accept_timeout", guard, 0);
        guard = 0;
        while (m_kind != 0 && guard < 50) begin
          tick(); guard++;
        end
        chk("alt_mode", cnt_mode, (h == 0));
      end
      chk("alt_return", cnt_q, start);
    end
    cmd_if.cmd_valid = 1'b0;
    tick();

    // Randomized commands, edge-biased loads and occasional aborts.
    for (int i = 0; i < 2500; i++) begin
      cmd_if.cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_if.cmd_op = op_e'(2'($urandom_range(0, 3)));
      if (cmd_if.cmd_op == OP_LOAD) begin
        case ($urandom_range(0, 4))
          0: a = 10'h000;
          1: a = 10'h001;
          2: a = 10'h3FE;
          3: a = 10'h3FF;
          default: a = W'($urandom_range(0, MAXV));
        endcase
      end else begin
        a = W'($urandom_range(0, 6));
      end
      cmd_if.cmd_arg = a;
      abort = ($urandom_range(0, 11) == 0);
      tick();
    end
    cmd_if.cmd_valid = 1'b0; abort = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
